axis_latency_monitor: RTL and testbench

//  Passive, synthesizable per-request latency monitor for the zynq_aes AXI4-Stream datapath.

---
 rtl/zynq_aes_mon_pkg.sv | 15 +
 rtl/axis_lat_ts_fifo.sv | 44 ++++
 rtl/axis_latency_monitor.sv | 104 ++++++++++
 tb/tb_axis_latency_monitor.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/zynq_aes_mon_pkg.sv
// zynq_aes_mon_pkg: shared types, default widths and saturating-increment helper for the latency monitor
package zynq_aes_mon_pkg;
  localparam int DEF_TS_W  = 32;
  localparam int DEF_ACC_W = 48;
  localparam int DEF_CNT_W = 32;
  typedef logic [DEF_TS_W-1:0]  ts_t;
  typedef logic [DEF_ACC_W-1:0] acc_t;
  typedef logic [DEF_CNT_W-1:0] cnt_t;
  typedef enum logic {IDLE, IN_PKT} pkt_state_e;
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= m) ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/axis_lat_ts_fifo.sv
// axis_lat_ts_fifo: first-word-fall-through timestamp FIFO (aclk, aresetn, clear, push/din in; pop in; dout/full/empty/count out)
module axis_lat_ts_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout  = mem[rd_ptr];
  // a pop frees a slot in the same cycle, so a full FIFO still accepts a simultaneous push
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & (~full | do_pop) & ~clear;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge aclk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/axis_latency_monitor.sv
// axis_latency_monitor: passive AXIS request latency monitor (snooped s/m handshakes in; last/min/max/total latency, counts, flags out)
module axis_latency_monitor
  import zynq_aes_mon_pkg::*;
#(
  parameter int TS_W  = 32,
  parameter int ACC_W = 48,
  parameter int CNT_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   clear,
  input  logic                   enable,
  input  logic                   s_tvalid,
  input  logic                   s_tready,
  input  logic                   s_tlast,
  input  logic                   m_tvalid,
  input  logic                   m_tready,
  input  logic                   m_tlast,
  output logic                   stat_valid,
  output logic [TS_W-1:0]        last_latency,
  output logic [TS_W-1:0]        min_latency,
  output logic [TS_W-1:0]        max_latency,
  output logic [ACC_W-1:0]       total_latency,
  output logic [CNT_W-1:0]       req_count,
  output logic [CNT_W-1:0]       drop_count,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   overflow,
  output logic                   underflow
);
  pkt_state_e      state, state_nxt;
  logic [TS_W-1:0] ts, head, lat;
  logic            s_hs, m_hs, start, push, cmp, pop_ok, drop, full, empty;
  logic [ACC_W:0]  sum;
  assign s_hs   = s_tvalid & s_tready;
  assign m_hs   = m_tvalid & m_tready;
  assign start  = s_hs & (state == IDLE);
  assign push   = start & enable;
  assign cmp    = m_hs & m_tlast;
  assign pop_ok = cmp & ~empty;
  assign drop   = push & full & ~pop_ok;
  // modular subtraction keeps latency correct across timestamp wrap
  assign lat    = ts - head;
  assign sum    = {1'b0, total_latency} + (ACC_W+1)'(lat);
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? ((s_hs & ~s_tlast) ? IN_PKT : IDLE)
                                : ((s_hs & s_tlast) ? IDLE : IN_PKT);
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else state <= clear ? IDLE : state_nxt;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) ts <= '0;
    else ts <= ts + 1'b1;
  axis_lat_ts_fifo #(.DEPTH(DEPTH), .W(TS_W)) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clear   (clear),
    .push    (push),
    .pop     (cmp),
    .din     (ts),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .count   (outstanding)
  );
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      stat_valid    <= 1'b0;
      last_latency  <= '0;
      min_latency   <= '1;
      max_latency   <= '0;
      total_latency <= '0;
      req_count     <= '0;
      drop_count    <= '0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else if (clear) begin
      stat_valid    <= 1'b0;
      last_latency  <= '0;
      min_latency   <= '1;
      max_latency   <= '0;
      total_latency <= '0;
      req_count     <= '0;
      drop_count    <= '0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      stat_valid <= pop_ok;
      if (pop_ok) begin
        last_latency  <= lat;
        min_latency   <= (lat < min_latency) ? lat : min_latency;
        max_latency   <= (lat > max_latency) ? lat : max_latency;
        total_latency <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        req_count     <= CNT_W'(sat_inc(64'(req_count), CNT_W));
      end
      if (drop) begin
        drop_count <= CNT_W'(sat_inc(64'(drop_count), CNT_W));
        overflow   <= 1'b1;
      end
      if (cmp & empty) underflow <= 1'b1;
    end
endmodule

// File: tb/tb_axis_latency_monitor.sv
// tb_axis_latency_monitor: directed scoreboard bench for axis_latency_monitor
module tb_axis_latency_monitor;
  logic        aclk, aresetn, clear, enable;
  logic        s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;
  logic        stat_valid, overflow, underflow;
  logic [7:0]  last_latency, min_latency, max_latency;
  logic [47:0] total_latency;
  logic [31:0] req_count, drop_count;
  logic [2:0]  outstanding;
  logic [7:0]  tb_ts;
  int unsigned sb[$];
  int          total = 0;
  int          bad = 0;

  axis_latency_monitor #(.TS_W(8), .ACC_W(48), .CNT_W(32), .DEPTH(4)) dut (
    .aclk(aclk), .aresetn(aresetn), .clear(clear), .enable(enable),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .stat_valid(stat_valid), .last_latency(last_latency), .min_latency(min_latency),
    .max_latency(max_latency), .total_latency(total_latency), .req_count(req_count),
    .drop_count(drop_count), .outstanding(outstanding), .overflow(overflow),
    .underflow(underflow)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // reference cycle counter: value seen by the DUT at the next rising edge
  always @(posedge aclk or negedge aresetn)
    if (!aresetn) tb_ts <= 8'd0;
    else tb_ts <= tb_ts + 8'd1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge aclk)
    if (aresetn && stat_valid) begin
      if (sb.size() == 0) chk("unexpected_stat_valid", 64'(last_latency), 64'hFFFF_FFFF);
      else chk("sb_latency", 64'(last_latency), 64'(sb.pop_front()));
    end

  task automatic tick(input logic sv, input logic sl, input logic mv, input logic ml, input logic clr);
    s_tvalid = sv; s_tready = sv; s_tlast = sl;
    m_tvalid = mv; m_tready = mv; m_tlast = ml; clear = clr;
    @(posedge aclk);
    #1;
    s_tvalid = 0; s_tready = 0; s_tlast = 0;
    m_tvalid = 0; m_tready = 0; m_tlast = 0; clear = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 0, 0);
  endtask

  initial begin
    aresetn = 0; clear = 0; enable = 1;
    s_tvalid = 0; s_tready = 0; s_tlast = 0; m_tvalid = 0; m_tready = 0; m_tlast = 0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_min", 64'(min_latency), 64'hFF);
    chk("rst_max", 64'(max_latency), 0);
    chk("rst_req", 64'(req_count), 0);
    chk("rst_outstanding", 64'(outstanding), 0);
    chk("rst_stat_valid", 64'(stat_valid), 0);
    aresetn = 1;
    idle(2);

    // single 4-beat request, completion 20 cycles after first beat
    sb.push_back(20);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    chk("t1_outstanding", 64'(outstanding), 1);
    idle(16);
    tick(0, 0, 1, 1, 0);
    chk("t1_stat_valid", 64'(stat_valid), 1);
    chk("t1_last", 64'(last_latency), 20);
    chk("t1_min", 64'(min_latency), 20);
    chk("t1_max", 64'(max_latency), 20);
    chk("t1_total", 64'(total_latency), 20);
    chk("t1_req", 64'(req_count), 1);
    idle(1);
    chk("t1_pulse_end", 64'(stat_valid), 0);

    // three pipelined requests: 15, 9, 30
    tick(0, 0, 0, 0, 1);
    chk("clr_min", 64'(min_latency), 64'hFF);
    chk("clr_req", 64'(req_count), 0);
    sb.push_back(15); sb.push_back(9); sb.push_back(30);
    tick(1, 1, 0, 0, 0);
    idle(9);
    tick(1, 1, 0, 0, 0);
    idle(1);
    tick(1, 1, 0, 0, 0);
    chk("t2_peak", 64'(outstanding), 3);
    idle(2);
    tick(0, 0, 1, 1, 0);
    idle(3);
    tick(0, 0, 1, 1, 0);
    idle(22);
    tick(0, 0, 1, 1, 0);
    chk("t2_min", 64'(min_latency), 9);
    chk("t2_max", 64'(max_latency), 30);
    chk("t2_total", 64'(total_latency), 54);
    chk("t2_req", 64'(req_count), 3);
    chk("t2_outstanding", 64'(outstanding), 0);

    // overflow: 5 starts into depth 4, then full+pop+start
    tick(0, 0, 0, 0, 1);
    repeat (5) tick(1, 1, 0, 0, 0);
    chk("t3_outstanding", 64'(outstanding), 4);
    chk("t3_drop", 64'(drop_count), 1);
    chk("t3_overflow", 64'(overflow), 1);
    sb.push_back(5);
    tick(1, 1, 1, 1, 0);
    chk("t3_last", 64'(last_latency), 5);
    chk("t3_fullpop_outstanding", 64'(outstanding), 4);
    chk("t3_fullpop_drop", 64'(drop_count), 1);

    // enable=0 start is neither pushed nor dropped
    tick(0, 0, 0, 0, 1);
    enable = 0;
    tick(1, 1, 0, 0, 0);
    enable = 1;
    chk("t3b_disabled_outstanding", 64'(outstanding), 0);
    chk("t3b_disabled_drop", 64'(drop_count), 0);

    // underflow on empty FIFO
    tick(0, 0, 1, 1, 0);
    chk("t4_underflow", 64'(underflow), 1);
    chk("t4_req", 64'(req_count), 0);
    chk("t4_stat_valid", 64'(stat_valid), 0);

    // timestamp wrap: start at 250, complete at 4
    tick(0, 0, 0, 0, 1);
    for (int i = 0; i < 300 && tb_ts != 8'd250; i++) idle(1);
    sb.push_back(10);
    tick(1, 1, 0, 0, 0);
    for (int i = 0; i < 300 && tb_ts != 8'd4; i++) idle(1);
    tick(0, 0, 1, 1, 0);
    chk("t5_wrap_last", 64'(last_latency), 10);
    chk("t5_req", 64'(req_count), 1);

    // clear coincident with completion
    tick(1, 1, 0, 0, 0);
    tick(0, 0, 1, 1, 1);
    chk("t6_stat_valid", 64'(stat_valid), 0);
    chk("t6_min", 64'(min_latency), 64'hFF);
    chk("t6_req", 64'(req_count), 0);
    chk("t6_outstanding", 64'(outstanding), 0);

    // async reset with two requests in flight
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    chk("t7_inflight", 64'(outstanding), 2);
    #2 aresetn = 0;
    #1;
    chk("t7_rst_outstanding", 64'(outstanding), 0);
    @(posedge aclk);
    #1 aresetn = 1;
    tick(0, 0, 1, 1, 0);
    tick(0, 0, 1, 1, 0);
    chk("t7_req", 64'(req_count), 0);
    chk("t7_stat_valid", 64'(stat_valid), 0);
    chk("t7_underflow", 64'(underflow), 1);
    idle(2);
    chk("sb_drained", 64'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
